// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: control FSM for an N x N systolic MLP datapath.
// Walks each layer through weight wait, weight load, activation streaming,
// pipeline drain and post-activation transfer, and drives the datapath strobes.
// Every strobe is computed from the next-state values and registered, so the
// outputs are clean Moore decodes with no combinational path from any input.
module mlp_layer_sequencer #(
  parameter int N          = 3,
  parameter int MAX_LAYERS = 4,
  parameter int ROW_W      = 8,
  parameter int ACT_LAT    = 4,
  localparam int LW        = $clog2(MAX_LAYERS + 1),
  localparam int CW        = ROW_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LW-1:0]    num_layers,
  input  logic [ROW_W-1:0] num_rows,
  input  logic             weights_ready,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [3:0]       state,
  output logic [LW-1:0]    layer,
  output logic [CW-1:0]    cycle_cnt,
  output logic             wf_pop,
  output logic             en_weight_pass,
  output logic [N-1:0]     en_capture,
  output logic             act_rd_ready,
  output logic [N-1:0]     row_valid,
  output logic             acc_enable,
  output logic             buffer_select,
  output logic             refill_en
);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    LOAD_WEIGHT  = 4'd1,
    COMPUTE      = 4'd3,
    DRAIN        = 4'd4,
    TRANSFER     = 4'd5,
    NEXT_LAYER   = 4'd6,
    WAIT_WEIGHTS = 4'd7,
    DONE         = 4'd8
  } state_t;

  localparam logic [CW-1:0] LOAD_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] ACC_FIRST  = CW'(2 * N - 1);
  localparam logic [CW-1:0] DRAIN_TAIL = CW'(2 * N - 2);
  localparam logic [CW-1:0] XFER_LAST  = CW'(ACT_LAT - 1);
  localparam logic [LW-1:0] LAYER_CAP  = LW'(MAX_LAYERS);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      layer_q, layer_d;
  logic [LW-1:0]      lnum_q, lnum_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic               bsel_q, bsel_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wf_pop_q, wf_pop_d;
  logic               ewp_q, ewp_d;
  logic [N-1:0]       cap_q, cap_d;
  logic               ard_q, ard_d;
  logic [N-1:0]       rv_q, rv_d;
  logic               acc_q, acc_d;
  logic               refill_q, refill_d;

  logic               stream_d;
  logic [CW-1:0]      stream_end_d;

  // Next-state, counter, layer and captured-configuration logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    lnum_d  = lnum_q;
    rows_d  = rows_q;
    bsel_d  = bsel_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (num_layers == '0)            lnum_d = LW'(1);
          else if (num_layers > LAYER_CAP) lnum_d = LAYER_CAP;
          else                             lnum_d = num_layers;
          rows_d  = (num_rows == '0) ? ROW_W'(1) : num_rows;
          layer_d = '0;
          bsel_d  = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_WEIGHTS;
        end
      end
      WAIT_WEIGHTS: begin
        if (weights_ready) begin
          state_d = LOAD_WEIGHT;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD_WEIGHT: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(rows_q) - CW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == CW'(rows_q) + DRAIN_TAIL) begin
          state_d = TRANSFER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRANSFER: begin
        if (cnt_q == XFER_LAST) begin
          cnt_d   = '0;
          state_d = (layer_q == lnum_q - LW'(1)) ? DONE : NEXT_LAYER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      NEXT_LAYER: begin
        layer_d = layer_q + LW'(1);
        bsel_d  = ~bsel_q;
        cnt_d   = '0;
        state_d = WAIT_WEIGHTS;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      layer_d = '0;
      bsel_d  = 1'b0;
    end
  end

  // Strobe decode of the upcoming state so the registered strobes line up with it.
  always_comb begin
    stream_d     = (state_d == COMPUTE) || (state_d == DRAIN);
    stream_end_d = CW'(rows_d) + DRAIN_TAIL;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    wf_pop_d     = (state_d == LOAD_WEIGHT);
    ewp_d        = (state_d == LOAD_WEIGHT);
    cap_d        = (state_d == LOAD_WEIGHT) ? (N'(1) << cnt_d) : '0;
    ard_d        = (state_d == COMPUTE);
    acc_d        = stream_d && (cnt_d >= ACC_FIRST) && (cnt_d <= stream_end_d);
    refill_d     = (state_d == TRANSFER);
    rv_d         = '0;
    for (int i = 0; i < N; i++) begin
      rv_d[i] = stream_d && (cnt_d >= CW'(i)) && (cnt_d < CW'(i) + CW'(rows_d));
    end
  end

  // All state and registered outputs; reset returns everything to idle zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      layer_q  <= '0;
      lnum_q   <= '0;
      rows_q   <= '0;
      bsel_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wf_pop_q <= 1'b0;
      ewp_q    <= 1'b0;
      cap_q    <= '0;
      ard_q    <= 1'b0;
      rv_q     <= '0;
      acc_q    <= 1'b0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      layer_q  <= layer_d;
      lnum_q   <= lnum_d;
      rows_q   <= rows_d;
      bsel_q   <= bsel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wf_pop_q <= wf_pop_d;
      ewp_q    <= ewp_d;
      cap_q    <= cap_d;
      ard_q    <= ard_d;
      rv_q     <= rv_d;
      acc_q    <= acc_d;
      refill_q <= refill_d;
    end
  end

  assign state          = state_q;
  assign cycle_cnt      = cnt_q;
  assign layer          = layer_q;
  assign buffer_select  = bsel_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign wf_pop         = wf_pop_q;
  assign en_weight_pass = ewp_q;
  assign en_capture     = cap_q;
  assign act_rd_ready   = ard_q;
  assign row_valid      = rv_q;
  assign acc_enable     = acc_q;
  assign refill_en      = refill_q;

endmodule
